de_agex_ctrl: RTL and testbench

DE_AGEX_CTRL -- requirements
Module: de_agex_ctrl

---
 rtl/lc3b_types.sv | 17 +
 rtl/de_agex_ctrl_scoreboard.sv | 59 +++++
 rtl/de_agex_ctrl.sv | 118 +++++++++++
 tb/tb_de_agex_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types and the DE/AGEX interlock state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;
  typedef logic [19:0] lc3b_twenty;

  localparam int unsigned NUM_REGS_DEFAULT = 8;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DEP_STALL = 2'd1,
    MEM_STALL = 2'd2,
    FLUSH     = 2'd3
  } agex_state_e;

endpackage

// File: rtl/de_agex_ctrl_scoreboard.sv
// Per-register pending-write counters: netted inc/dec/flush-decrement updates
// clamped to 0..3, plus the source-busy lookup used for the RAW hazard.
module de_agex_ctrl_scoreboard
  import lc3b_types::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    i_inc_en,
  input  lc3b_nzp i_inc_id,
  input  logic    i_dec_en,
  input  lc3b_nzp i_dec_id,
  input  logic    i_fdec_en,
  input  lc3b_nzp i_fdec_id,
  input  logic    i_src1_used,
  input  lc3b_nzp i_src1,
  input  logic    i_src2_used,
  input  lc3b_nzp i_src2,
  output logic    o_src_busy
);

  logic [1:0] r_pend     [NUM_REGS];
  logic [2:0] w_up_sum   [NUM_REGS];
  logic [2:0] w_dn       [NUM_REGS];
  logic [2:0] w_net      [NUM_REGS];
  logic [1:0] w_pend_nxt [NUM_REGS];

  // Net all same-cycle updates to a register before clamping to 0..3.
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      w_up_sum[r] = {1'b0, r_pend[r]} + {2'b00, (i_inc_en && (i_inc_id == lc3b_nzp'(r)))};
      w_dn[r]     = {2'b00, (i_dec_en && (i_dec_id == lc3b_nzp'(r)))}
                  + {2'b00, (i_fdec_en && (i_fdec_id == lc3b_nzp'(r)))};
      w_net[r]    = w_up_sum[r] - w_dn[r];
      if (w_up_sum[r] < w_dn[r]) begin
        w_pend_nxt[r] = 2'd0;
      end else if (w_net[r] > 3'd3) begin
        w_pend_nxt[r] = 2'd3;
      end else begin
        w_pend_nxt[r] = w_net[r][1:0];
      end
    end
  end

  // NOTE: this array is tiny control state whose zero value is architecturally
  // meaningful, so unlike a RAM it is cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) r_pend[r] <= 2'd0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) r_pend[r] <= w_pend_nxt[r];
    end
  end

  assign o_src_busy = (i_src1_used && (r_pend[i_src1] != 2'd0))
                   || (i_src2_used && (r_pend[i_src2] != 2'd0));

endmodule

// File: rtl/de_agex_ctrl.sv
// DE->AGEX pipeline-latch control: flush > mem-stall > RAW hazard > run,
// with a one-cycle post-flush bubble and a saturating dependency-stall counter.
module de_agex_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        de_v,
  input  logic        de_sr1_used,
  input  logic        de_sr2_used,
  input  logic        de_ld_reg,
  input  lc3b_nzp     de_sr1,
  input  lc3b_nzp     de_sr2,
  input  lc3b_nzp     de_drid,
  input  logic        mem_stall,
  input  logic        br_flush,
  input  logic        sr_v,
  input  logic        sr_ld_reg,
  input  lc3b_nzp     sr_drid,
  output logic        load_agex,
  output logic        agex_bubble,
  output logic        agex_v,
  output logic        load_de,
  output logic        dep_stall,
  output logic [15:0] dep_stall_cnt
);

  agex_state_e r_state;
  agex_state_e w_state_nxt;
  logic        w_src_busy;
  logic        w_hazard;
  logic        r_agex_v;
  logic        r_agex_ld_q;
  lc3b_nzp     r_agex_drid_q;
  logic [15:0] r_dep_stall_cnt;

  assign w_hazard = de_v & w_src_busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    if (br_flush)       w_state_nxt = FLUSH;
    else if (mem_stall) w_state_nxt = MEM_STALL;
    else if (w_hazard)  w_state_nxt = DEP_STALL;
    else                w_state_nxt = RUN;
  end

  // NOTE: every output is defaulted before the priority chain so no path can
  // leave one unassigned and infer a latch; the defaults are the reset values.
  always_comb begin
    load_agex   = 1'b1;
    agex_bubble = 1'b1;
    load_de     = 1'b0;
    dep_stall   = 1'b0;
    if (reset_n) begin
      if (br_flush) begin
        load_de = 1'b1;
      end else if (mem_stall) begin
        load_agex = 1'b0;
      end else if (w_hazard) begin
        dep_stall = 1'b1;
      end else if (r_state == FLUSH) begin
        load_de = 1'b1;
      end else begin
        agex_bubble = ~de_v;
        load_de     = 1'b1;
      end
    end
  end

  // A bubble entering AGEX carries no valid instruction and no pending write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_agex_v        <= 1'b0;
      r_agex_ld_q     <= 1'b0;
      r_agex_drid_q   <= '0;
      r_dep_stall_cnt <= '0;
    end else begin
      if (load_agex) begin
        r_agex_v      <= ~agex_bubble;
        r_agex_ld_q   <= ~agex_bubble & de_ld_reg;
        r_agex_drid_q <= de_drid;
      end
      if (dep_stall && (r_dep_stall_cnt != 16'hFFFF)) begin
        r_dep_stall_cnt <= r_dep_stall_cnt + 16'd1;
      end
    end
  end

  assign agex_v        = r_agex_v;
  assign dep_stall_cnt = r_dep_stall_cnt;

  de_agex_ctrl_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_inc_en    (load_agex & ~agex_bubble & de_ld_reg),
    .i_inc_id    (de_drid),
    .i_dec_en    (sr_v & sr_ld_reg),
    .i_dec_id    (sr_drid),
    .i_fdec_en   (br_flush & r_agex_v & r_agex_ld_q),
    .i_fdec_id   (r_agex_drid_q),
    .i_src1_used (de_sr1_used),
    .i_src1      (de_sr1),
    .i_src2_used (de_sr2_used),
    .i_src2      (de_sr2),
    .o_src_busy  (w_src_busy)
  );

endmodule

// File: tb/tb_de_agex_ctrl.sv
// Scoreboard bench for de_agex_ctrl: a driver issues stimulus and queues the
// expected response from a rule-level model; a monitor pops and compares.
module tb_de_agex_ctrl;

  typedef struct packed {
    bit       rst_n;
    bit       de_v;
    bit       sr1_used;
    bit       sr2_used;
    bit       ld_reg;
    bit [2:0] sr1;
    bit [2:0] sr2;
    bit [2:0] drid;
    bit       mem_stall;
    bit       br_flush;
    bit       sr_v;
    bit       sr_ld_reg;
    bit [2:0] sr_drid;
  } stim_t;

  typedef struct packed {
    bit        la;
    bit        bub;
    bit        lde;
    bit        ds;
    bit        av;
    bit [15:0] cnt;
    bit [15:0] pend;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        de_v, de_sr1_used, de_sr2_used, de_ld_reg;
  logic [2:0]  de_sr1, de_sr2, de_drid;
  logic        mem_stall, br_flush, sr_v, sr_ld_reg;
  logic [2:0]  sr_drid;
  logic        load_agex, agex_bubble, agex_v, load_de, dep_stall;
  logic [15:0] dep_stall_cnt;

  de_agex_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .de_v          (de_v),
    .de_sr1_used   (de_sr1_used),
    .de_sr2_used   (de_sr2_used),
    .de_ld_reg     (de_ld_reg),
    .de_sr1        (de_sr1),
    .de_sr2        (de_sr2),
    .de_drid       (de_drid),
    .mem_stall     (mem_stall),
    .br_flush      (br_flush),
    .sr_v          (sr_v),
    .sr_ld_reg     (sr_ld_reg),
    .sr_drid       (sr_drid),
    .load_agex     (load_agex),
    .agex_bubble   (agex_bubble),
    .agex_v        (agex_v),
    .load_de       (load_de),
    .dep_stall     (dep_stall),
    .dep_stall_cnt (dep_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int mon_cyc  = 0;
  exp_t exp_q[$];

  // Reference model: outstanding writes per register, what sits in AGEX,
  // whether the previous cycle flushed, and the stall count.
  int       m_pend [8];
  bit       m_flush = 0;
  bit       m_av    = 0;
  bit       m_ald   = 0;
  bit [2:0] m_adrid = 0;
  int       m_cnt   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, mon_cyc, act, req);
    end
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    bit   hz;
    int   np [8];
    int   n_bad;
    @(negedge clk);
    reset_n     = s.rst_n;
    de_v        = s.de_v;
    de_sr1_used = s.sr1_used;
    de_sr2_used = s.sr2_used;
    de_ld_reg   = s.ld_reg;
    de_sr1      = s.sr1;
    de_sr2      = s.sr2;
    de_drid     = s.drid;
    mem_stall   = s.mem_stall;
    br_flush    = s.br_flush;
    sr_v        = s.sr_v;
    sr_ld_reg   = s.sr_ld_reg;
    sr_drid     = s.sr_drid;

    hz = s.de_v && ((s.sr1_used && m_pend[s.sr1] > 0) || (s.sr2_used && m_pend[s.sr2] > 0));
    e = '0;
    if (!s.rst_n)          begin e.la = 1; e.bub = 1;         e.lde = 0; end
    else if (s.br_flush)   begin e.la = 1; e.bub = 1;         e.lde = 1; end
    else if (s.mem_stall)  begin e.la = 0; e.bub = 1;         e.lde = 0; end
    else if (hz)           begin e.la = 1; e.bub = 1;         e.lde = 0; e.ds = 1; end
    else if (m_flush)      begin e.la = 1; e.bub = 1;         e.lde = 1; end
    else                   begin e.la = 1; e.bub = !s.de_v;   e.lde = 1; end
    e.av  = m_av;
    e.cnt = 16'(m_cnt);
    for (int r = 0; r < 8; r++) e.pend[2*r +: 2] = 2'(m_pend[r]);
    exp_q.push_back(e);

    if (!s.rst_n) begin
      for (int r = 0; r < 8; r++) m_pend[r] = 0;
      m_flush = 0; m_av = 0; m_ald = 0; m_adrid = 0; m_cnt = 0;
    end else begin
      for (int r = 0; r < 8; r++) np[r] = m_pend[r];
      if (e.la && !e.bub && s.ld_reg) np[s.drid]++;
      if (s.sr_v && s.sr_ld_reg)       np[s.sr_drid]--;
      if (s.br_flush && m_av && m_ald) np[m_adrid]--;
      n_bad = 0;
      for (int r = 0; r < 8; r++) begin
        if (np[r] < 0 || np[r] > 3) n_bad++;
        m_pend[r] = (np[r] < 0) ? 0 : (np[r] > 3) ? 3 : np[r];
      end
      check("pend_range", n_bad, 0);
      if (e.ds && m_cnt < 65535) m_cnt++;
      if (e.la) begin
        m_av    = !e.bub;
        m_ald   = !e.bub && s.ld_reg;
        m_adrid = s.drid;
      end
      m_flush = s.br_flush;
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s;
    s = '0;
    drive(s);
    drive(s);
  endtask

  task automatic rand_cycle();
    stim_t s;
    int    avail;
    s.rst_n     = ($urandom_range(0, 99) != 0);
    s.de_v      = ($urandom_range(0, 9) < 8);
    s.sr1_used  = 1'($urandom_range(0, 1));
    s.sr2_used  = 1'($urandom_range(0, 1));
    s.ld_reg    = 1'($urandom_range(0, 1));
    s.sr1       = 3'($urandom_range(0, 7));
    s.sr2       = 3'($urandom_range(0, 7));
    s.drid      = 3'($urandom_range(0, 7));
    s.mem_stall = ($urandom_range(0, 99) < 15);
    s.br_flush  = ($urandom_range(0, 99) < 6);
    s.sr_v      = 1'($urandom_range(0, 1));
    s.sr_ld_reg = ($urandom_range(0, 3) != 0);
    s.sr_drid   = 3'($urandom_range(0, 7));
    // Keep stimulus legal: no write beyond 3 in flight, no retire or squash
    // of a register that has nothing outstanding.
    if (m_pend[s.drid] == 3) s.ld_reg = 0;
    if (s.br_flush && m_av && m_ald && m_pend[m_adrid] == 0) s.br_flush = 0;
    avail = m_pend[s.sr_drid]
          - ((s.br_flush && m_av && m_ald && m_adrid == s.sr_drid) ? 1 : 0);
    if (avail < 1) s.sr_ld_reg = 0;
    drive(s);
  endtask

  // Monitor: outputs are valid every cycle; sample mid-low-phase.
  initial begin
    exp_t       e;
    logic [15:0] act_pend;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int r = 0; r < 8; r++) act_pend[2*r +: 2] = dut.u_sb.r_pend[r];
        check("load_agex", load_agex, e.la);
        if (e.la) check("agex_bubble", agex_bubble, e.bub);
        check("load_de", load_de, e.lde);
        check("dep_stall", dep_stall, e.ds);
        check("agex_v", agex_v, e.av);
        check("dep_stall_cnt", dep_stall_cnt, e.cnt);
        check("pend", act_pend, e.pend);
        mon_cyc++;
      end
    end
  end

  initial begin
    stim_t s;
    reset_n = 0; de_v = 0; de_sr1_used = 0; de_sr2_used = 0; de_ld_reg = 0;
    de_sr1 = 0; de_sr2 = 0; de_drid = 0; mem_stall = 0; br_flush = 0;
    sr_v = 0; sr_ld_reg = 0; sr_drid = 0;
    for (int r = 0; r < 8; r++) m_pend[r] = 0;

    do_reset();
    repeat (3000) rand_cycle();

    // Write-then-read of R1: stall until the cycle after its retire.
    do_reset();
    s = idle(); s.de_v = 1; s.ld_reg = 1; s.drid = 3'd1; drive(s);
    s = idle(); s.de_v = 1; s.sr1_used = 1; s.sr1 = 3'd1;
    repeat (3) drive(s);
    s.sr_v = 1; s.sr_ld_reg = 1; s.sr_drid = 3'd1; drive(s);
    s.sr_v = 0; s.sr_ld_reg = 0; drive(s);

    // Memory stall over a pending hazard holds everything for 5 cycles.
    do_reset();
    s = idle(); s.de_v = 1; s.ld_reg = 1; s.drid = 3'd2; drive(s);
    s = idle(); s.de_v = 1; s.sr2_used = 1; s.sr2 = 3'd2; s.mem_stall = 1;
    repeat (5) drive(s);
    s.mem_stall = 0; drive(s);

    // Flush squashes AGEX's write to R3, then one forced bubble cycle.
    do_reset();
    s = idle(); s.de_v = 1; s.ld_reg = 1; s.drid = 3'd3; drive(s);
    s = idle(); s.de_v = 1; s.br_flush = 1; drive(s);
    s.br_flush = 0; drive(s);
    drive(s);

    // Same-cycle increment and decrement of R2 nets to no change.
    do_reset();
    s = idle(); s.de_v = 1; s.ld_reg = 1; s.drid = 3'd2; drive(s);
    s.sr_v = 1; s.sr_ld_reg = 1; s.sr_drid = 3'd2; drive(s);
    s = idle(); drive(s);

    // Reset in the middle of a dependency stall with two writes to R5 pending.
    do_reset();
    s = idle(); s.de_v = 1; s.ld_reg = 1; s.drid = 3'd5; drive(s); drive(s);
    s = idle(); s.de_v = 1; s.sr1_used = 1; s.sr1 = 3'd5; drive(s); drive(s);
    s.rst_n = 0; drive(s);
    s = idle(); s.de_v = 1; drive(s);

    // Long dependency stall saturates the counter.
    do_reset();
    s = idle(); s.de_v = 1; s.ld_reg = 1; s.drid = 3'd4; drive(s);
    s = idle(); s.de_v = 1; s.sr2_used = 1; s.sr2 = 3'd4;
    repeat (65540) drive(s);
    drive(idle());

    @(negedge clk);
    @(negedge clk);
    #4;
    check("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
